// File: rtl/uart_transceiver.sv
// 8N1 UART transmitter and receiver sharing one clock; the transmitter serialises
// bytes on txd and the receiver recovers bytes from an asynchronous rxd line.
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_bus,
    input  logic       rst_bus,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t        tx_state, tx_state_next;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]       tx_idx, tx_idx_next;
    logic [7:0]       tx_byte, tx_byte_next;
    logic             txd_next;
    logic             tx_bit_done;

    rx_state_t        rx_state, rx_state_next;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]       rx_idx, rx_idx_next;
    logic [7:0]       rx_shift, rx_shift_next;
    logic [7:0]       rx_data_next;
    logic             rx_meta, rxs;
    logic             rx_bit_done, rx_half, rx_good, rx_bad;

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_idx   <= tx_idx_next;
            tx_byte  <= tx_byte_next;
            txd      <= txd_next;
        end
    end

    always_comb begin
        tx_bit_done   = (tx_cnt == CNT_LAST);
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_start) tx_state_next = TX_START;
            TX_START: if (tx_bit_done) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_bit_done && tx_idx == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_bit_done) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    // txd is registered, so it is driven from the state being entered, not the current one
    always_comb begin
        tx_busy      = (tx_state != TX_IDLE);
        tx_cnt_next  = (tx_state == TX_IDLE || tx_bit_done) ? '0 : tx_cnt + CNT_W'(1);
        tx_idx_next  = (tx_state == TX_DATA && tx_bit_done) ? tx_idx + 3'd1 : tx_idx;
        tx_byte_next = (tx_state == TX_IDLE && tx_start) ? tx_data : tx_byte;
        case (tx_state_next)
            TX_START: txd_next = 1'b0;
            TX_DATA:  txd_next = tx_byte_next[tx_idx_next];
            default:  txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_ready     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta      <= rxd;
            rxs          <= rx_meta;
            rx_state     <= rx_state_next;
            rx_cnt       <= rx_cnt_next;
            rx_idx       <= rx_idx_next;
            rx_shift     <= rx_shift_next;
            rx_data      <= rx_data_next;
            rx_ready     <= rx_good;
            rx_frame_err <= rx_bad;
        end
    end

    always_comb begin
        rx_bit_done   = (rx_cnt == CNT_LAST);
        rx_half       = (rx_cnt == CNT_HALF);
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rxs) rx_state_next = RX_START;
            RX_START:     if (rx_half) rx_state_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_bit_done && rx_idx == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:      if (rx_bit_done) rx_state_next = rxs ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rxs) rx_state_next = RX_IDLE;
            default:      rx_state_next = RX_IDLE;
        endcase
    end

    // The start-bit wait lands mid-bit, so every later full-period wrap is also mid-bit
    always_comb begin
        case (rx_state)
            RX_START:         rx_cnt_next = rx_half ? '0 : rx_cnt + CNT_W'(1);
            RX_DATA, RX_STOP: rx_cnt_next = rx_bit_done ? '0 : rx_cnt + CNT_W'(1);
            default:          rx_cnt_next = '0;
        endcase
        rx_idx_next   = (rx_state == RX_DATA && rx_bit_done) ? rx_idx + 3'd1 : rx_idx;
        rx_shift_next = (rx_state == RX_DATA && rx_bit_done) ? {rxs, rx_shift[7:1]} : rx_shift;
        rx_good       = (rx_state == RX_STOP) && rx_bit_done && rxs;
        rx_bad        = (rx_state == RX_STOP) && rx_bit_done && !rxs;
        rx_data_next  = rx_good ? rx_shift : rx_data;
    end

endmodule
